// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and instruction layout.
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         INST_W    = 12;
  localparam int         OPC_W     = 6;
  localparam int         OPR_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  // Instruction halves carry six payload bits; the top two bits of a HI/LO byte must be zero.
  function automatic logic is_six_bit(input logic [7:0] b);
    return (b[7:6] == 2'b00);
  endfunction

endpackage

// File: rtl/loader_timeout_ctr.sv
// Inter-byte watchdog for the loader. Clears on clear_i or when disabled, and flags expiry
// once it has sat at TIMEOUT_CYCLES-1 while enabled. reset is asynchronous, active-low.
module loader_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned    CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A byte accepted in the expiry cycle wins, so clear_i masks the flag.
  assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: unpacks framed bytes (A5, LEN, LEN x {HI,LO}) into 12-bit program words and
// releases the CPU once a full image is written. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = 64,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned CNT_W   = $clog2(MEM_DEPTH + 1);
  localparam logic [7:0]  MAX_LEN = 8'(MEM_DEPTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [INST_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic accept;
  logic tmo_en;
  logic tmo_expired;
  logic enter_err;
  logic enter_done;

  assign rx_ready = (state_q != ST_WRITE);
  assign accept   = rx_valid && rx_ready;
  assign tmo_en   = (state_q == ST_LEN) || (state_q == ST_HI) ||
                    (state_q == ST_LO)  || (state_q == ST_CSUM);

  loader_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (accept),
    .enable_i  (tmo_en),
    .expired_o (tmo_expired)
  );

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    opc_d      = opc_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    run_d      = run_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    enter_err  = 1'b0;
    enter_done = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
          run_d   = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          addr_d  = '0;
          cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      ST_LEN: begin
        if (accept) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN)) begin
            enter_err = 1'b1;
          end else begin
            len_d   = rx_data[CNT_W-1:0];
            state_d = ST_HI;
          end
        end else if (tmo_expired) begin
          enter_err = 1'b1;
        end
      end

      ST_HI: begin
        if (accept) begin
          if (!is_six_bit(rx_data)) begin
            enter_err = 1'b1;
          end else begin
            opc_d   = rx_data[OPC_W-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ rx_data;
`endif
            state_d = ST_LO;
          end
        end else if (tmo_expired) begin
          enter_err = 1'b1;
        end
      end

      ST_LO: begin
        if (accept) begin
          if (!is_six_bit(rx_data)) begin
            enter_err = 1'b1;
          end else begin
            wdata_d = {opc_q, rx_data[OPR_W-1:0]};
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ rx_data;
`endif
            state_d = ST_WRITE;
          end
        end else if (tmo_expired) begin
          enter_err = 1'b1;
        end
      end

      // The strobe itself is decoded from the state; here only the bookkeeping advances.
      ST_WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_d == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d    = ST_CSUM;
`else
          enter_done = 1'b1;
`endif
        end else begin
          state_d = ST_HI;
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            enter_done = 1'b1;
          end else begin
            enter_err = 1'b1;
          end
        end else if (tmo_expired) begin
          enter_err = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_err) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      run_d   = 1'b0;
      done_d  = 1'b0;
    end else if (enter_done) begin
      state_d = ST_DONE;
      run_d   = 1'b1;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      opc_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_run   = run_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule
